// File: rtl/mvp_pkg.sv
// Shared definitions for the bit-serial shift-accumulate block: default sizing
// and the controller state encoding.
package mvp_pkg;

    localparam int N_DEF    = 64;
    localparam int SW_DEF   = $clog2(N_DEF) + 2;
    localparam int ACCW_DEF = 32;

    // Shift amount width: the largest shift is 15 + 15 = 30.
    localparam int SHW = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/mvp_shacc_lane.sv
// One row of the shift-accumulate datapath: shifts the row's bit-plane sum into
// place, optionally negates it (sign-bit weight) and adds it to the accumulator.
module mvp_shacc_lane
    import mvp_pkg::*;
#(
    parameter int SW   = SW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic            neg,
    input  logic [SHW-1:0]  shamt,
    input  logic [SW-1:0]   s,
    output logic [ACCW-1:0] acc
);

    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] acc_d;
    logic [ACCW-1:0] term;

    // Next accumulator value; arithmetic wraps modulo 2^ACCW.
    always_comb begin
        term  = ACCW'(s) << shamt;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = neg ? (acc_q - term) : (acc_q + term);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mvp_shacc.sv
// Shift-accumulate controller for bit-serial matrix-vector products. Bit-plane
// sums arrive weight-bit-major, MSB first; each row weights them by 2^(i+j)
// and applies a negative weight for two's complement sign bits.
//
// Handshakes: a beat moves on s_in when s_valid && s_ready at a rising edge;
// the result moves on m_data when m_valid && m_ready at a rising edge. A
// producer holds its data stable while valid is high and ready is low.
module mvp_shacc
    import mvp_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int SW   = $clog2(N) + 2,
    parameter int ACCW = ACCW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        iprec,
    input  logic [3:0]        wprec,
    input  logic              isign,
    input  logic              wsign,
    input  logic              s_valid,
    input  logic [N*SW-1:0]   s_in,
    output logic              s_ready,
    output logic              m_valid,
    output logic [N*ACCW-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output state_e            dbg_state
);

    state_e         state_q, state_d;
    logic [3:0]     iprec_q, iprec_d;
    logic [3:0]     wprec_q, wprec_d;
    logic           isign_q, isign_d;
    logic           wsign_q, wsign_d;
    logic [3:0]     i_cnt_q, i_cnt_d;
    logic [3:0]     j_cnt_q, j_cnt_d;
    logic           s_ready_q, s_ready_d;
    logic           m_valid_q, m_valid_d;
    logic           busy_q, busy_d;

    logic           clr;
    logic           beat;
    logic           last_beat;
    logic [3:0]     i_bit;
    logic [3:0]     j_bit;
    logic [SHW-1:0] shamt;
    logic           neg;

    // Counters run upward from zero; the bit index is precision minus count,
    // so count zero always means the sign (most significant) bit.
    always_comb begin
        i_bit     = iprec_q - i_cnt_q;
        j_bit     = wprec_q - j_cnt_q;
        shamt     = SHW'(i_bit) + SHW'(j_bit);
        neg       = (isign_q && (i_cnt_q == 4'd0)) ^ (wsign_q && (j_cnt_q == 4'd0));
        beat      = s_valid && s_ready_q;
        last_beat = (i_cnt_q == iprec_q) && (j_cnt_q == wprec_q);
    end

    // Controller next-state, config latching and registered-output decode.
    always_comb begin
        state_d = state_q;
        iprec_d = iprec_q;
        wprec_d = wprec_q;
        isign_d = isign_q;
        wsign_d = wsign_q;
        i_cnt_d = i_cnt_q;
        j_cnt_d = j_cnt_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    iprec_d = iprec;
                    wprec_d = wprec;
                    isign_d = isign;
                    wsign_d = wsign;
                    i_cnt_d = 4'd0;
                    j_cnt_d = 4'd0;
                    clr     = 1'b1;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (beat) begin
                    if (last_beat) begin
                        i_cnt_d = 4'd0;
                        j_cnt_d = 4'd0;
                        state_d = ST_OUT;
                    end else if (i_cnt_q == iprec_q) begin
                        i_cnt_d = 4'd0;
                        j_cnt_d = j_cnt_q + 4'd1;
                    end else begin
                        i_cnt_d = i_cnt_q + 4'd1;
                    end
                end
            end
            ST_OUT: begin
                if (m_valid_q && m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        s_ready_d = (state_d == ST_ACC);
        m_valid_d = (state_d == ST_OUT);
        busy_d    = (state_d != ST_IDLE);
    end

    // Controller state, latched configuration, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            iprec_q   <= 4'd0;
            wprec_q   <= 4'd0;
            isign_q   <= 1'b0;
            wsign_q   <= 1'b0;
            i_cnt_q   <= 4'd0;
            j_cnt_q   <= 4'd0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            iprec_q   <= iprec_d;
            wprec_q   <= wprec_d;
            isign_q   <= isign_d;
            wsign_q   <= wsign_d;
            i_cnt_q   <= i_cnt_d;
            j_cnt_q   <= j_cnt_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            busy_q    <= busy_d;
        end
    end

    // One datapath lane per row; the lanes' registers are the result bus.
    for (genvar r = 0; r < N; r++) begin : g_lane
        mvp_shacc_lane #(
            .SW   (SW),
            .ACCW (ACCW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (beat),
            .neg   (neg),
            .shamt (shamt),
            .s     (s_in[r*SW +: SW]),
            .acc   (m_data[r*ACCW +: ACCW])
        );
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
